// File: rtl/stage_one_arith_if.sv
// stage_one_arith_if: bundles the multiplier, adder/subtractor and timer signals of
// stage_one_arith.
//   master modport: driven by the stage controller (operands, enables, timer control)
//   slave  modport: stage_one_arith itself (mul_result, as_result, dly_done)
// Optional macro STAGE_ONE_ARITH_ADDSUB_OVF_EN adds the as_overflow signal.
interface stage_one_arith_if #(
   parameter int unsigned FLT_DATA_WIDTH = 32,
   parameter int unsigned CRD_DATA_WIDTH = 24,
   parameter int unsigned COUNTER_WIDTH  = 10
);
   logic                      mul_en;
   logic [FLT_DATA_WIDTH-1:0] mul_a;
   logic [FLT_DATA_WIDTH-1:0] mul_b;
   logic [FLT_DATA_WIDTH-1:0] mul_result;
   logic                      as_add_sub;
   logic [CRD_DATA_WIDTH-1:0] as_a;
   logic [CRD_DATA_WIDTH-1:0] as_b;
   logic [CRD_DATA_WIDTH-1:0] as_result;
`ifdef STAGE_ONE_ARITH_ADDSUB_OVF_EN
   logic                      as_overflow;
`endif
   logic                      dly_start;
   logic [COUNTER_WIDTH-1:0]  dly_max;
   logic                      dly_done;

   modport master (
      output mul_en, mul_a, mul_b, as_add_sub, as_a, as_b, dly_start, dly_max,
`ifdef STAGE_ONE_ARITH_ADDSUB_OVF_EN
      input  as_overflow,
`endif
      input  mul_result, as_result, dly_done
   );

   modport slave (
      input  mul_en, mul_a, mul_b, as_add_sub, as_a, as_b, dly_start, dly_max,
`ifdef STAGE_ONE_ARITH_ADDSUB_OVF_EN
      output as_overflow,
`endif
      output mul_result, as_result, dly_done
   );
endinterface

// File: rtl/stage_one_arith.sv
// stage_one_arith: arithmetic support for the first CORDIC stage.
//   - 3-stage pipelined single-precision multiplier (mul_en stalls all stages)
//   - combinational 24-bit add/subtract, wrap-around
//   - programmable delay timer, saturating at dly_max
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  stage_one_arith_if.slave (mul_*, as_*, dly_* signals)
// Optional macro STAGE_ONE_ARITH_ADDSUB_OVF_EN drives bus.as_overflow (signed overflow flag).
module stage_one_arith #(
   parameter int unsigned FLT_DATA_WIDTH = 32,
   parameter int unsigned CRD_DATA_WIDTH = 24,
   parameter int unsigned COUNTER_WIDTH  = 10
) (
   input logic              clk,
   input logic              rst,
   stage_one_arith_if.slave bus
);
   localparam int unsigned FRAC_W = FLT_DATA_WIDTH - 9;
   localparam int unsigned MANT_W = FRAC_W + 1;
   localparam int unsigned PROD_W = 2 * MANT_W;
   localparam logic [FLT_DATA_WIDTH-1:0] QNAN = FLT_DATA_WIDTH'(32'h7FC0_0000);

   // ---------------- Multiplier stage 1: unpack and classify ----------------
   logic              a_sign, b_sign;
   logic [7:0]        a_exp, b_exp;
   logic [FRAC_W-1:0] a_frac, b_frac;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign {a_sign, a_exp, a_frac} = bus.mul_a;
   assign {b_sign, b_exp, b_frac} = bus.mul_b;

   // Subnormals count as zero
   assign a_zero = (a_exp == 8'h00);
   assign b_zero = (b_exp == 8'h00);
   assign a_inf  = (a_exp == 8'hFF) && (a_frac == '0);
   assign b_inf  = (b_exp == 8'hFF) && (b_frac == '0);
   assign a_nan  = (a_exp == 8'hFF) && (a_frac != '0);
   assign b_nan  = (b_exp == 8'hFF) && (b_frac != '0);

   logic              s1_sign, s1_nan, s1_inf, s1_zero;
   logic signed [9:0] s1_exp;
   logic [MANT_W-1:0] s1_ma, s1_mb;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_sign <= 1'b0;
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
         s1_zero <= 1'b0;
         s1_exp  <= '0;
         s1_ma   <= '0;
         s1_mb   <= '0;
      end else if (bus.mul_en) begin
         s1_sign <= a_sign ^ b_sign;
         s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
         s1_inf  <= a_inf | b_inf;
         s1_zero <= a_zero | b_zero;
         s1_exp  <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
         s1_ma   <= {1'b1, a_frac};
         s1_mb   <= {1'b1, b_frac};
      end
   end

   // ---------------- Multiplier stage 2: mantissa product ----------------
   logic              s2_sign, s2_nan, s2_inf, s2_zero;
   logic signed [9:0] s2_exp;
   logic [PROD_W-1:0] s2_prod;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sign <= 1'b0;
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
         s2_zero <= 1'b0;
         s2_exp  <= '0;
         s2_prod <= '0;
      end else if (bus.mul_en) begin
         s2_sign <= s1_sign;
         s2_nan  <= s1_nan;
         s2_inf  <= s1_inf;
         s2_zero <= s1_zero;
         s2_exp  <= s1_exp;
         s2_prod <= PROD_W'(s1_ma) * PROD_W'(s1_mb);
      end
   end

   // ---------------- Multiplier stage 3: normalize, round, pack ----------------
   logic                      norm_hi, guard, sticky, round_up;
   logic [FRAC_W-1:0]         mant;
   logic [MANT_W-1:0]         mant_inc;
   logic signed [9:0]         exp_adj;
   logic [FLT_DATA_WIDTH-1:0] res_d, mul_result_q;

   always_comb begin
      norm_hi = s2_prod[PROD_W-1];
      mant    = s2_prod[PROD_W-3 -: FRAC_W];
      guard   = s2_prod[PROD_W-3-FRAC_W];
      sticky  = |s2_prod[PROD_W-4-FRAC_W:0];
      // Product in [2,4): take one bit higher and bump the exponent
      if (norm_hi) begin
         mant   = s2_prod[PROD_W-2 -: FRAC_W];
         guard  = s2_prod[PROD_W-2-FRAC_W];
         sticky = |s2_prod[PROD_W-3-FRAC_W:0];
      end
      round_up = guard & (sticky | mant[0]);
      mant_inc = {1'b0, mant} + MANT_W'(round_up);
      // Rounding carry-out leaves fraction bits at zero, only the exponent moves
      exp_adj  = s2_exp + $signed({9'b0, norm_hi}) + $signed({9'b0, mant_inc[FRAC_W]});

      res_d = {s2_sign, exp_adj[7:0], mant_inc[FRAC_W-1:0]};
      if (s2_nan) begin
         res_d = QNAN;
      end else if (s2_inf) begin
         res_d = {s2_sign, 8'hFF, FRAC_W'(0)};
      end else if (s2_zero || (exp_adj < 10'sd1)) begin
         res_d = {s2_sign, (FLT_DATA_WIDTH-1)'(0)};
      end else if (exp_adj > 10'sd254) begin
         res_d = {s2_sign, 8'hFF, FRAC_W'(0)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_result_q <= '0;
      end else if (bus.mul_en) begin
         mul_result_q <= res_d;
      end
   end

   assign bus.mul_result = mul_result_q;

   // ---------------- Adder / subtractor ----------------
   logic [CRD_DATA_WIDTH-1:0] as_sum;

   assign as_sum        = bus.as_add_sub ? (bus.as_a + bus.as_b) : (bus.as_a - bus.as_b);
   assign bus.as_result = as_sum;

`ifdef STAGE_ONE_ARITH_ADDSUB_OVF_EN
   localparam int unsigned MSB = CRD_DATA_WIDTH - 1;
   // Add overflows with like-signed operands, subtract with unlike-signed ones
   assign bus.as_overflow = (bus.as_add_sub ? (bus.as_a[MSB] == bus.as_b[MSB])
                                            : (bus.as_a[MSB] != bus.as_b[MSB]))
                            && (as_sum[MSB] != bus.as_a[MSB]);
`endif

   // ---------------- Delay timer ----------------
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic                     done_q, done_d;

   always_comb begin
      count_d = count_q;
      done_d  = done_q;
      if (bus.dly_start) begin
         count_d = '0;
         done_d  = 1'b0;
      end else if (count_q >= bus.dly_max) begin
         // At or beyond the terminal count (dly_max may have dropped): freeze
         done_d = 1'b1;
      end else begin
         count_d = count_q + 1'b1;
         if (count_d == bus.dly_max) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign bus.dly_done = done_q;

endmodule

// File: tb/tb_stage_one_arith.sv
// tb_stage_one_arith: directed self-checking bench for stage_one_arith.
module tb_stage_one_arith;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   stage_one_arith_if bus ();

   stage_one_arith dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Operands sampled at the first edge, result visible after the third
   task automatic mul_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
      bus.mul_en = 1'b1;
      bus.mul_a  = a;
      bus.mul_b  = b;
      tick();
      bus.mul_a = 32'h0;
      bus.mul_b = 32'h0;
      tick();
      tick();
      check(tag, bus.mul_result, exp);
   endtask

   task automatic as_chk(input string tag, input logic add, input logic [23:0] a,
                         input logic [23:0] b, input logic [23:0] exp, input logic ovf);
      bus.as_add_sub = add;
      bus.as_a       = a;
      bus.as_b       = b;
      #1;
      check(tag, {8'h0, bus.as_result}, {8'h0, exp});
`ifdef STAGE_ONE_ARITH_ADDSUB_OVF_EN
      check({tag, "_ovf"}, {31'h0, bus.as_overflow}, {31'h0, ovf});
`else
      if (ovf) begin end
`endif
   endtask

   task automatic done_chk(input string tag, input logic exp);
      check(tag, {31'h0, bus.dly_done}, {31'h0, exp});
   endtask

   initial begin
      rst            = 1'b1;
      bus.mul_en     = 1'b0;
      bus.mul_a      = 32'h0;
      bus.mul_b      = 32'h0;
      bus.as_add_sub = 1'b1;
      bus.as_a       = 24'h0;
      bus.as_b       = 24'h0;
      bus.dly_start  = 1'b0;
      bus.dly_max    = 10'd1023;
      tick();
      tick();
      check("reset_mul", bus.mul_result, 32'h0);
      done_chk("reset_done", 1'b0);
      rst = 1'b0;

      // Single products and specials
      mul_one("mul_3x0p5", 32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000);
      mul_one("mul_2x2", 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      mul_one("mul_neg_half", 32'hC040_0000, 32'h3F00_0000, 32'hBFC0_0000);
      mul_one("mul_round", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
      mul_one("mul_inf_x_0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
      mul_one("mul_ninf_x_2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
      mul_one("mul_overflow", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
      mul_one("mul_subnormal", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
      mul_one("mul_nan_in", 32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000);

      // Back-to-back
      bus.mul_en = 1'b1;
      bus.mul_a  = 32'h4040_0000;
      bus.mul_b  = 32'h3F00_0000;
      tick();
      bus.mul_a = 32'h4000_0000;
      bus.mul_b = 32'h4000_0000;
      tick();
      bus.mul_a = 32'h0;
      bus.mul_b = 32'h0;
      tick();
      check("b2b_first", bus.mul_result, 32'h3FC0_0000);
      tick();
      check("b2b_second", bus.mul_result, 32'h4080_0000);
      tick();
      tick();
      check("b2b_flush", bus.mul_result, 32'h0);

      // Stall: results delayed by the disabled cycles, output held meanwhile
      bus.mul_a = 32'h4040_0000;
      bus.mul_b = 32'h3F00_0000;
      tick();
      bus.mul_a = 32'h4000_0000;
      bus.mul_b = 32'h4000_0000;
      tick();
      bus.mul_en = 1'b0;
      bus.mul_a  = 32'h3F80_0000;
      bus.mul_b  = 32'h3F80_0000;
      tick();
      tick();
      check("stall_hold0", bus.mul_result, 32'h0);
      bus.mul_en = 1'b1;
      bus.mul_a  = 32'h0;
      bus.mul_b  = 32'h0;
      tick();
      check("stall_first", bus.mul_result, 32'h3FC0_0000);
      bus.mul_en = 1'b0;
      tick();
      tick();
      check("stall_hold1", bus.mul_result, 32'h3FC0_0000);
      bus.mul_en = 1'b1;
      tick();
      check("stall_second", bus.mul_result, 32'h4080_0000);

      // Adder / subtractor
      as_chk("as_sub_offset", 1'b0, 24'h28_0000, 24'h20_0000, 24'h08_0000, 1'b0);
      as_chk("as_add_wrap", 1'b1, 24'h7F_FFFF, 24'h00_0001, 24'h80_0000, 1'b1);
      as_chk("as_sub_neg", 1'b0, 24'h00_0000, 24'h00_0001, 24'hFF_FFFF, 1'b0);
      as_chk("as_sub_ovf", 1'b0, 24'h80_0000, 24'h00_0001, 24'h7F_FFFF, 1'b1);

      // Timer, dly_max = 4
      bus.dly_max   = 10'd4;
      bus.dly_start = 1'b1;
      tick();
      bus.dly_start = 1'b0;
      done_chk("dly_after_pulse", 1'b0);
      tick();
      tick();
      tick();
      done_chk("dly_edge3", 1'b0);
      tick();
      done_chk("dly_edge4", 1'b1);
      tick();
      tick();
      done_chk("dly_held", 1'b1);
      bus.dly_start = 1'b1;
      tick();
      bus.dly_start = 1'b0;
      done_chk("dly_restart_clr", 1'b0);
      tick();
      tick();
      tick();
      done_chk("dly_restart_e3", 1'b0);
      tick();
      done_chk("dly_restart_e4", 1'b1);

      // dly_max = 0
      bus.dly_max   = 10'd0;
      bus.dly_start = 1'b1;
      tick();
      done_chk("dly0_pulse", 1'b0);
      bus.dly_start = 1'b0;
      tick();
      done_chk("dly0_done", 1'b1);

      // Lowering dly_max below the current count stops the timer
      bus.dly_max   = 10'd10;
      bus.dly_start = 1'b1;
      tick();
      bus.dly_start = 1'b0;
      repeat (5) tick();
      done_chk("dly_mid_run", 1'b0);
      bus.dly_max = 10'd2;
      tick();
      done_chk("dly_lowered", 1'b1);
      tick();
      done_chk("dly_lowered_hold", 1'b1);

      // Reset during a pending product and a running count
      bus.dly_max   = 10'd3;
      bus.dly_start = 1'b1;
      bus.mul_en    = 1'b1;
      bus.mul_a     = 32'h4040_0000;
      bus.mul_b     = 32'h3F00_0000;
      tick();
      bus.dly_start = 1'b0;
      bus.mul_a     = 32'h0;
      bus.mul_b     = 32'h0;
      rst           = 1'b1;
      bus.dly_max   = 10'd0;
      tick();
      check("rst_mul", bus.mul_result, 32'h0);
      done_chk("rst_done", 1'b0);
      rst         = 1'b0;
      bus.dly_max = 10'd3;
      tick();
      tick();
      check("rst_discard", bus.mul_result, 32'h0);
      done_chk("rst_count_e2", 1'b0);
      tick();
      done_chk("rst_count_e3", 1'b1);

      // rst and dly_start together: rst wins
      rst           = 1'b1;
      bus.dly_start = 1'b1;
      tick();
      done_chk("rst_and_start", 1'b0);
      rst           = 1'b0;
      bus.dly_start = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_one_arith.md
# stage_one_arith

Arithmetic support block for the first stage of the CORDIC front end. It bundles three independent units:
- a pipelined IEEE-754 single-precision multiplier, used for halving (x·0.5) and squaring (x·x);
- a combinational 24-bit two's-complement adder/subtractor, used to remove the 128.0 offset from a 10.14 fixed-point value;
- a programmable cycle-delay timer that sequences the stage controller.

## Interface
Parameters:
- FLT_DATA_WIDTH, 32, float operand width (fixed; other values unsupported)
- CRD_DATA_WIDTH, 24, adder/subtractor width
- COUNTER_WIDTH, 10, delay-counter width

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- mul_en  in  1  multiplier clock enable; 0 stalls every pipeline stage
- mul_a  in  32  float operand A
- mul_b  in  32  float operand B
- mul_result  out  32  float product, registered
- as_add_sub  in  1  1 = add, 0 = subtract (as_a − as_b)
- as_a  in  24  signed operand
- as_b  in  24  signed operand
- as_result  out  24  signed result, combinational
- dly_start  in  1  restart pulse for the timer
- dly_max  in  10  terminal count
- dly_done  out  1  timer reached dly_max, registered

## Operation
Multiplier:
- Result is sign = a^b, exponents added with rebias, 24×24 mantissa product, normalized, round-to-nearest-even.
- Subnormal inputs are treated as ±0; subnormal or underflowing results flush to signed zero.
- Overflow gives signed infinity.
- Any NaN input, or inf×0, gives canonical 0x7FC00000.
- inf×finite-nonzero gives signed infinity.

Adder/subtractor:
- Output is as_a + as_b or as_a − as_b, modulo 2^24 (wrap-around, no saturation).
- Purely combinational; no clock or reset dependence.

Timer:
- Internal count register, COUNTER_WIDTH bits.
- dly_start=1 clears count to 0 and dly_done to 0.
- Otherwise, if count != dly_max, count increments.
- dly_done is set (registered) in the cycle count equals dly_max and holds until the next dly_start or rst.
- Count saturates at dly_max and never wraps.
- dly_max=0: dly_done rises on the first edge after dly_start deasserts.
- Changing dly_max mid-count takes effect immediately. If the count is already past the new value, it continues until wrapping is impossible: it must stop. The required response is dly_done=1 and the count frozen.

## Timing
- Multiplier latency is exactly 3 enabled cycles: operands sampled at edge N (mul_en=1) appear on mul_result after edge N+2 of enabled clocking. Disabled cycles do not advance it.
- Throughput is one product per enabled cycle.
- mul_en=0 freezes all pipeline registers and mul_result.
- rst clears the pipeline and mul_result to 0x00000000 and clears count and dly_done to 0. rst has priority over mul_en and dly_start.
- rst mid-operation discards all in-flight products.
- After reset, without dly_start, the timer counts from 0 toward dly_max.
- dly_start and rst asserted together: rst wins, with the same cleared result.
- as_result settles within the same cycle as its inputs.

## Configuration
- Macro STAGE_ONE_ARITH_ADDSUB_OVF_EN.
- Defined: adds output port as_overflow (1 bit, combinational). It is 1 when the true signed result is outside [−2^23, 2^23−1], else 0.
- Undefined: the port does not exist; wrap-around behaviour is identical.

## Test plan
- mul_a=0x40400000 (3.0), mul_b=0x3F000000 (0.5), mul_en=1 -> mul_result=0x3FC00000 (1.5) three cycles later. With mul_a=mul_b=0x40000000 -> 0x40800000.
- Back-to-back products: 3.0×0.5 then 2.0×2.0 on consecutive cycles -> 0x3FC00000 then 0x40800000 on consecutive cycles. Insert mul_en=0 for 2 cycles -> output held and results delayed by 2 cycles.
- Specials:
  - 0x7F800000×0x00000000 -> 0x7FC00000
  - 0xFF800000×0x40000000 -> 0xFF800000
  - 0x7F000000×0x7F000000 -> 0x7F800000
  - 0x00000001×0x3F800000 -> 0x00000000
- Adder/subtractor:
  - as_a=0x280000 (160.0 in 10.14), as_b=0x200000, sub -> 0x080000
  - 0x7FFFFF+0x000001 add -> 0x800000, with as_overflow=1 when the macro is defined
  - 0x000000−0x000001 -> 0xFFFFFF
- Timer: dly_max=4, dly_start pulse 1 cycle -> dly_done=1 on the 4th edge after the pulse, held. A second pulse clears dly_done and repeats. With dly_max=0, dly_done=1 one edge after the pulse.
- rst asserted during a pending product and a running count -> mul_result=0, dly_done=0 on the next edge. The pending product never appears.
